// File: rtl/sprite_line_renderer_if.sv
// Start/done handshake plus the OAM and VRAM read ports of the sprite line renderer.
// The renderer is the master: it issues reads and reports progress.
interface sprite_line_renderer_if #(
  parameter int OAM_ADDR_SIZE  = 8,
  parameter int OAM_DATA_SIZE  = 32,
  parameter int VRAM_ADDR_SIZE = 12,
  parameter int VRAM_DATA_SIZE = 128
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      oam_re;
  logic [OAM_ADDR_SIZE-1:0]  oam_a;
  logic [OAM_DATA_SIZE-1:0]  oam_d;
  logic                      vram_re;
  logic [VRAM_ADDR_SIZE-1:0] vram_a;
  logic [VRAM_DATA_SIZE-1:0] vram_d;

  modport master (
    input  start, oam_d, vram_d,
    output busy, done, oam_re, oam_a, vram_re, vram_a
  );

  modport slave (
    output start, oam_d, vram_d,
    input  busy, done, oam_re, oam_a, vram_re, vram_a
  );
endinterface

// File: rtl/sprite_line_renderer.sv
// Scanline sprite renderer: walks the secondary array, fetches OAM and VRAM rows,
// and composites each hit sprite into a line buffer with flips, clipping and first-wins overlap.
module sprite_line_renderer #(
  parameter int VRAM_ADDR_SIZE    = 12,
  parameter int SPRITE_SIZE       = 16,
  parameter int COLOR_DEPTH       = 8,
  parameter int VRAM_DATA_SIZE    = SPRITE_SIZE * COLOR_DEPTH,
  parameter int SECOND_ARRAY_SIZE = 32,
  parameter int OAM_ADDR_SIZE     = 8,
  parameter int OAM_DATA_SIZE     = 32,
  parameter int DISPLAY_WIDTH     = 640,
  parameter int DISPLAY_HEIGHT    = 480,
  parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  sprite_line_renderer_if.master                          bus,
  input  logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]   second_array,
  input  logic [LINE_NUMBER_WIDTH-1:0]                    line_number,
  output logic [DISPLAY_WIDTH-1:0][COLOR_DEPTH-1:0]       line_buffer,
  output logic [DISPLAY_WIDTH-1:0]                        line_priority
);
  localparam int ROW_W = $clog2(SPRITE_SIZE);
  localparam int IDX_W = $clog2(SECOND_ARRAY_SIZE + 1);
  localparam int SEL_W = $clog2(SECOND_ARRAY_SIZE);
  localparam int XW    = $clog2(DISPLAY_WIDTH);
  localparam int CW    = 11;

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, OAM_WAIT, VRAM_REQ, VRAM_WAIT, DRAW, DONE
  } state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [9:0]                xpos_q;
  logic                      prio_q;
  logic                      xflip_q;
  logic [VRAM_DATA_SIZE-1:0] row_q;
  logic [DISPLAY_WIDTH-1:0]  occupied;

  // Next entry to visit; its read strobe is registered on the way into FETCH.
  logic [IDX_W-1:0]         fetch_n;
  logic                     fetch_go;
  logic [OAM_ADDR_SIZE-1:0] fetch_addr;
  always_comb begin
    fetch_n    = (state == CLEAR) ? '0 : idx + IDX_W'(1);
    fetch_go   = 1'b0;
    fetch_addr = '0;
    if (fetch_n < IDX_W'(SECOND_ARRAY_SIZE) && second_array[fetch_n[SEL_W-1:0]][0]) begin
      fetch_go   = 1'b1;
      fetch_addr = second_array[fetch_n[SEL_W-1:0]][OAM_ADDR_SIZE:1];
    end
  end

  // Vertical hit test at 11 bits so ypos+SPRITE_SIZE never wraps.
  logic [CW-1:0]    line_c, ypos_c;
  logic             hit;
  logic [ROW_W-1:0] row;
  always_comb begin
    line_c = CW'(line_number);
    ypos_c = CW'(bus.oam_d[27:18]);
    hit    = bus.oam_d[31] && (line_c >= ypos_c) && (line_c < ypos_c + CW'(SPRITE_SIZE));
    row    = ROW_W'(line_c - ypos_c);
    if (bus.oam_d[30]) row = ROW_W'(SPRITE_SIZE - 1) - row;
  end

  logic [SPRITE_SIZE-1:0]                  px_we;
  logic [SPRITE_SIZE-1:0][XW-1:0]          px_x;
  logic [SPRITE_SIZE-1:0][COLOR_DEPTH-1:0] px_c;
  logic [CW-1:0]                           sx;
  always_comb begin
    px_we = '0;
    px_x  = '0;
    px_c  = '0;
    sx    = '0;
    for (int i = 0; i < SPRITE_SIZE; i++) begin
      px_c[i]  = xflip_q ? row_q[(SPRITE_SIZE-1-i)*COLOR_DEPTH +: COLOR_DEPTH]
                         : row_q[i*COLOR_DEPTH +: COLOR_DEPTH];
      sx       = CW'(xpos_q) + CW'(i);
      px_x[i]  = sx[XW-1:0];
      px_we[i] = (px_c[i] != '0) && (sx < CW'(DISPLAY_WIDTH)) && !occupied[sx[XW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.oam_re    <= 1'b0;
      bus.oam_a     <= '0;
      bus.vram_re   <= 1'b0;
      bus.vram_a    <= '0;
      xpos_q        <= '0;
      prio_q        <= 1'b0;
      xflip_q       <= 1'b0;
      row_q         <= '0;
      line_buffer   <= '0;
      line_priority <= '0;
      occupied      <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state    <= CLEAR;
          bus.busy <= 1'b1;
        end
        CLEAR: begin
          line_buffer   <= '0;
          line_priority <= '0;
          occupied      <= '0;
          idx           <= fetch_n;
          bus.oam_re    <= fetch_go;
          bus.oam_a     <= fetch_addr;
          state         <= FETCH;
        end
        FETCH: begin
          bus.oam_re <= 1'b0;
          bus.oam_a  <= '0;
          if (bus.oam_re) begin
            state <= OAM_WAIT;
          end else begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        OAM_WAIT: begin
          xpos_q  <= bus.oam_d[17:8];
          prio_q  <= bus.oam_d[28];
          xflip_q <= bus.oam_d[29];
          if (hit) begin
            bus.vram_re <= 1'b1;
            bus.vram_a  <= VRAM_ADDR_SIZE'({bus.oam_d[7:0], row});
            state       <= VRAM_REQ;
          end else begin
            idx        <= fetch_n;
            bus.oam_re <= fetch_go;
            bus.oam_a  <= fetch_addr;
            state      <= FETCH;
          end
        end
        VRAM_REQ: begin
          bus.vram_re <= 1'b0;
          bus.vram_a  <= '0;
          state       <= VRAM_WAIT;
        end
        VRAM_WAIT: begin
          row_q <= bus.vram_d;
          state <= DRAW;
        end
        DRAW: begin
          for (int i = 0; i < SPRITE_SIZE; i++) begin
            if (px_we[i]) begin
              line_buffer[px_x[i]]   <= px_c[i];
              line_priority[px_x[i]] <= prio_q;
              occupied[px_x[i]]      <= 1'b1;
            end
          end
          idx        <= fetch_n;
          bus.oam_re <= fetch_go;
          bus.oam_a  <= fetch_addr;
          state      <= FETCH;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
